// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer: state encoding, default width, counter sizing.
// The PARITY state exists only when PISO_PARITY_EN is defined.
package piso_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
`ifdef PISO_PARITY_EN
        PARITY = S_PARITY,
`endif
        SHIFT  = S_SHIFT
    } state_t;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for the serializer; last flags the final data bit of a word.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       clear,
    input  logic                       enable,
    output logic [cnt_w(WIDTH)-1:0]    count,
    output logic                       last
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

    // clear wins over enable so a back-to-back word restarts at position 0
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and frame markers.
// Define PISO_PARITY_EN to append an even-parity bit as an extra frame cycle.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    state_t                  state;
    state_t                  state_nxt;
    logic [WIDTH-1:0]        shreg;
    logic                    armed;
    logic                    accept;
    logic                    tx_bit;
    logic                    cnt_clear;
    logic                    cnt_en;
    logic [cnt_w(WIDTH)-1:0] count;
    logic                    last;
`ifdef PISO_PARITY_EN
    logic                    par_bit;
`endif

    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0) begin
            return {v[WIDTH-2:0], 1'b0};
        end
        return {1'b0, v[WIDTH-1:1]};
    endfunction

    piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk    (clk),
        .clr_n  (clr_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (count),
        .last   (last)
    );

    assign accept = load_valid && load_ready;
    assign tx_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

    // armed holds load_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= data_in;
        end else if (state == SHIFT) begin
            shreg <= shift_one(shreg);
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= ^data_in;
        end
    end
`endif

    always_comb begin
        state_nxt   = state;
        load_ready  = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        busy        = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        case (state)
            IDLE: begin
                load_ready = armed;
                if (load_valid && armed) begin
                    state_nxt = SHIFT;
                    cnt_clear = 1'b1;
                end
            end
            SHIFT: begin
                ser_valid   = 1'b1;
                busy        = 1'b1;
                ser_out     = tx_bit;
                frame_start = (count == '0);
                cnt_en      = 1'b1;
                if (last) begin
                    cnt_clear = 1'b1;
`ifdef PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    frame_end  = 1'b1;
                    load_ready = 1'b1;
                    state_nxt  = load_valid ? SHIFT : IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                ser_valid  = 1'b1;
                busy       = 1'b1;
                ser_out    = par_bit;
                frame_end  = 1'b1;
                load_ready = 1'b1;
                state_nxt  = load_valid ? SHIFT : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share stimulus and are
// compared every cycle against a queue-based frame model, plus directed table and corner sequences.
module tb_piso_serializer;

    localparam int W = 16;
`ifdef PISO_PARITY_EN
    localparam int FLEN = W + 1;
    localparam bit PAR  = 1'b1;
`else
    localparam int FLEN = W;
    localparam bit PAR  = 1'b0;
`endif

    logic         clk = 1'b1;
    logic         clr_n;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;

    logic m_load_ready, m_ser_out, m_ser_valid, m_frame_start, m_frame_end, m_busy;
    logic l_load_ready, l_ser_out, l_ser_valid, l_frame_start, l_frame_end, l_busy;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .clr_n(clr_n), .data_in(data_in), .load_valid(load_valid),
        .load_ready(m_load_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
        .frame_start(m_frame_start), .frame_end(m_frame_end), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .clr_n(clr_n), .data_in(data_in), .load_valid(load_valid),
        .load_ready(l_load_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
        .frame_start(l_frame_start), .frame_end(l_frame_end), .busy(l_busy)
    );

    // Model: the queue holds every serial slot still owed, one entry per cycle.
    typedef struct { logic [W-1:0] w; int idx; } slot_t;
    slot_t q[$];
    bit    armed = 1'b0;
    bit    acc = 1'b0;
    int    acc_cnt = 0;
    bit    chk_en = 1'b0;
    int    errors = 0;
    int    checks = 0;

    logic [31:0] col_m = '0, col_l = '0;
    int          vcnt = 0, fe_at = 0, fe_cnt = 0, run = 0, last_run = 0;
    logic        par_seen = 1'b0;

    typedef struct { logic [W-1:0] w; logic [W-1:0] rev; logic par; } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] expect_out(input bit msb);
        logic [5:0] e;
        slot_t      s;
        logic       b;
        e    = '0;
        e[5] = armed && (q.size() <= 1);
        if (q.size() > 0) begin
            s = q[0];
            if (s.idx == W) b = ^s.w;
            else            b = msb ? s.w[W-1-s.idx] : s.w[s.idx];
            e[4] = 1'b1;
            e[3] = 1'b1;
            e[2] = b;
            e[1] = (s.idx == 0);
            e[0] = PAR ? (s.idx == W) : (s.idx == W - 1);
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk or negedge clr_n);
        if (!clr_n) begin
            q.delete();
            armed = 1'b0;
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                for (int i = 0; i < FLEN; i++) q.push_back('{w: data_in, idx: i});
                acc_cnt++;
            end
            armed = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("msb_outputs", 32'({m_load_ready, m_busy, m_ser_valid, m_ser_out, m_frame_start, m_frame_end}),
                  32'(expect_out(1'b1)));
            check("lsb_outputs", 32'({l_load_ready, l_busy, l_ser_valid, l_ser_out, l_frame_start, l_frame_end}),
                  32'(expect_out(1'b0)));
        end
        if (m_ser_valid && !(PAR && m_frame_end)) col_m = {col_m[30:0], m_ser_out};
        if (l_ser_valid && !(PAR && l_frame_end)) col_l = {col_l[30:0], l_ser_out};
        if (m_ser_valid) begin
            vcnt++;
            run++;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (m_frame_end) begin
            fe_at = vcnt;
            fe_cnt++;
            par_seen = m_ser_out;
        end
        acc = clr_n && load_valid && armed && (q.size() <= 1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit keep);
        int a0;
        int n;
        a0 = acc_cnt;
        n  = 0;
        data_in    = w;
        load_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (acc_cnt == a0 && n < 4 * FLEN);
        check("accept_seen", 32'(acc_cnt != a0), 32'(1));
        if (!keep) load_valid = 1'b0;
    endtask

    initial begin
        int v0;
        int f0;
        tbl[0] = '{w: 16'h0001, rev: 16'h8000, par: 1'b1};
        tbl[1] = '{w: 16'h0007, rev: 16'hE000, par: 1'b1};
        tbl[2] = '{w: 16'h8000, rev: 16'h0001, par: 1'b1};
        tbl[3] = '{w: 16'hFFFF, rev: 16'hFFFF, par: 1'b0};
        tbl[4] = '{w: 16'h00F0, rev: 16'h0F00, par: 1'b0};
        tbl[5] = '{w: 16'hA5C3, rev: 16'hC3A5, par: 1'b0};
        tbl[6] = '{w: 16'h1234, rev: 16'h2C48, par: 1'b1};

        clr_n = 1'b1;
        #1 clr_n = 1'b0;
        #1 chk_en = 1'b1;
        #18;
        check("reset_outputs", 32'({m_load_ready, m_busy, m_ser_valid, m_ser_out, m_frame_start, m_frame_end,
                                    l_load_ready, l_busy, l_ser_valid, l_ser_out, l_frame_start, l_frame_end}), 32'(0));
        #7 clr_n = 1'b1;
        #1 check("ready_before_edge", 32'({m_load_ready, l_load_ready}), 32'(0));
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'({m_load_ready, l_load_ready, m_ser_valid, l_ser_valid}), 32'(4'b1100));

        for (int i = 0; i < 7; i++) begin
            v0 = vcnt;
            send_word(tbl[i].w, 1'b0);
            idle(FLEN + 2);
            check("tbl_msb_stream", 32'(col_m[15:0]), 32'(tbl[i].w));
            check("tbl_lsb_stream", 32'(col_l[15:0]), 32'(tbl[i].rev));
            check("tbl_frame_len", 32'(vcnt - v0), 32'(FLEN));
            check("tbl_frame_end_pos", 32'(fe_at - v0), 32'(FLEN));
`ifdef PISO_PARITY_EN
            check("tbl_parity", 32'(par_seen), 32'(tbl[i].par));
`endif
        end

        send_word(16'h0007, 1'b1);
        send_word(16'h8000, 1'b0);
        idle(FLEN + 3);
        check("b2b_msb_stream", col_m, 32'h0007_8000);
        check("b2b_lsb_stream", col_l, 32'hE000_0001);
        check("b2b_contiguous", 32'(last_run), 32'(2 * FLEN));

        f0 = fe_cnt;
        send_word(16'hFFFF, 1'b0);
        idle(5);
        @(negedge clk);
        #2;
        clr_n      = 1'b0;
        load_valid = 1'b1;
        data_in    = 16'h1234;
        #1;
        check("async_reset_outputs", 32'({m_busy, m_ser_valid, m_ser_out, m_frame_end, m_load_ready,
                                          l_busy, l_ser_valid, l_ser_out, l_frame_end, l_load_ready}), 32'(0));
        check("no_frame_end_truncated", 32'(fe_cnt - f0), 32'(0));
        idle(2);
        load_valid = 1'b0;
        @(negedge clk);
        #2 clr_n = 1'b1;
        idle(2);
        check("reset_wins_no_capture", 32'({m_ser_valid, m_busy, l_ser_valid, l_busy}), 32'(0));
        send_word(16'h00F0, 1'b0);
        idle(FLEN + 2);
        check("post_reset_msb", 32'(col_m[15:0]), 32'h00F0);
        check("post_reset_lsb", 32'(col_l[15:0]), 32'h0F00);

        repeat (400) begin
            load_valid = ($urandom_range(0, 3) != 0);
            data_in    = W'($urandom);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        idle(FLEN + 2);
        check("random_drained", 32'({m_busy, l_busy}), 32'(0));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
